// File: rtl/id_ex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_pipe
//
// Decode/control stage for the 5-stage RV32I core. The opcode of the
// instruction in IF/ID is decoded into a 12-bit control word and registered
// into the ID/EX pipeline register together with rd/rs1/rs2. The block also
// detects load-use hazards and inserts a bubble, squashes ID on a taken
// branch/jump, flags unknown opcodes and keeps saturating stall/flush counters.
//
// Parameters
//   CNT_W      width of stall_cnt / flush_cnt
//   HAZARD_EN  1: load-use detection active; 0: stall tied low
//   CTRL_W     control word width, only 12 is supported
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   id_instr      instruction in IF/ID
//   id_valid      id_instr is a real instruction
//   ex_flush      taken branch/jump resolved in EX, squash ID
//   stall         combinational, hold PC and IF/ID this cycle
//   ex_valid      ID/EX holds a real instruction
//   ex_ctrl       registered control word
//   ex_rd/rs1/rs2 registered register specifiers
//   ex_illegal    registered, instruction in EX has an unknown opcode
//   illegal_seen  sticky unknown-opcode flag, cleared only by rst
//   stall_cnt     saturating count of stall cycles
//   flush_cnt     saturating count of flush cycles
//
// Control word bits:
//   [0] ALUSrc [1] MemtoReg [2] RegWrite [3] MemRead [4] MemWrite
//   [5] Branch [7:6] ALUOp [8] Jump [9] Link [10] UpperImm [11] PCrelA
// ---------------------------------------------------------------------------
module id_ex_ctrl_pipe #(
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CTRL_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic              ex_illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ID-stage field extraction
  logic [6:0] id_opcode;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];

  // funct3/funct7 do not affect the control word at this stage
  logic unused_funct;
  assign unused_funct = ^{id_instr[31:25], id_instr[14:12]};

  // Decode
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              use_rs1;
  logic              use_rs2;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_ctrl = CTRL_W'(12'h084);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_I: begin
        dec_ctrl = CTRL_W'(12'h085);
        use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl = CTRL_W'(12'h00F);
        use_rs1  = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl = CTRL_W'(12'h011);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl = CTRL_W'(12'h060);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl = CTRL_W'(12'hB04);
      end
      OP_JALR: begin
        dec_ctrl = CTRL_W'(12'h305);
        use_rs1  = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl = CTRL_W'(12'h405);
      end
      OP_AUIPC: begin
        dec_ctrl = CTRL_W'(12'hC05);
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction
  // actually reads. x0 is never a real dependency.
  logic ex_valid_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [4:0] ex_rd_reg;
  logic [4:0] ex_rs1_reg;
  logic [4:0] ex_rs2_reg;
  logic ex_illegal_reg;
  logic illegal_seen_reg;
  logic load_use;

  generate
    if (HAZARD_EN) begin : g_hazard
      assign load_use = id_valid & ex_valid_reg & ex_ctrl_reg[3] &
                        (ex_rd_reg != 5'd0) &
                        ((use_rs1 & (id_rs1 == ex_rd_reg)) |
                         (use_rs2 & (id_rs2 == ex_rd_reg)));
    end else begin : g_no_hazard
      assign load_use = 1'b0;
    end
  endgenerate

  // A flush already discards the ID instruction, so stalling for it would
  // only waste a cycle. Reset forces stall low regardless of stale state.
  assign stall = load_use & ~ex_flush & ~rst;

  // ID/EX pipeline register. A bubble clears ctrl, so the MemRead bit that
  // caused a stall is gone the next cycle and the stall lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_ctrl_reg      <= '0;
      ex_rd_reg        <= 5'd0;
      ex_rs1_reg       <= 5'd0;
      ex_rs2_reg       <= 5'd0;
      ex_illegal_reg   <= 1'b0;
      illegal_seen_reg <= 1'b0;
    end else if (ex_flush || stall) begin
      ex_valid_reg   <= 1'b0;
      ex_ctrl_reg    <= '0;
      ex_illegal_reg <= 1'b0;
    end else begin
      ex_valid_reg <= id_valid;
      if (id_valid) begin
        ex_ctrl_reg    <= dec_ctrl;
        ex_rd_reg      <= id_rd;
        ex_rs1_reg     <= id_rs1;
        ex_rs2_reg     <= id_rs2;
        ex_illegal_reg <= dec_illegal;
        if (dec_illegal) begin
          illegal_seen_reg <= 1'b1;
        end
      end else begin
        ex_ctrl_reg    <= '0;
        ex_illegal_reg <= 1'b0;
      end
    end
  end

  // Saturating performance counters: index 0 counts stalls, 1 counts flushes.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = stall;
  assign cnt_inc[1] = ex_flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign ex_valid     = ex_valid_reg;
  assign ex_ctrl      = ex_ctrl_reg;
  assign ex_rd        = ex_rd_reg;
  assign ex_rs1       = ex_rs1_reg;
  assign ex_rs2       = ex_rs2_reg;
  assign ex_illegal   = ex_illegal_reg;
  assign illegal_seen = illegal_seen_reg;
  assign stall_cnt    = cnt_reg[0];
  assign flush_cnt    = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for id_ex_ctrl_pipe. Two instances share the stimulus: one with
// 16-bit counters and one with 2-bit counters to exercise saturation.
// A reference model tracks the EX stage from the decode table and the
// hazard/flush rules; directed scenarios run first, then random traffic.
// ---------------------------------------------------------------------------
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr = 32'd0;
  logic        id_valid = 1'b0;
  logic        ex_flush = 1'b0;

  logic        stall_a, ex_valid_a, ex_illegal_a, illegal_seen_a;
  logic [11:0] ex_ctrl_a;
  logic [4:0]  ex_rd_a, ex_rs1_a, ex_rs2_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;

  logic        stall_b, ex_valid_b, ex_illegal_b, illegal_seen_b;
  logic [11:0] ex_ctrl_b;
  logic [4:0]  ex_rd_b, ex_rs1_b, ex_rs2_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  id_ex_ctrl_pipe #(.CNT_W(16), .HAZARD_EN(1'b1), .CTRL_W(12)) dut_a (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_flush(ex_flush), .stall(stall_a), .ex_valid(ex_valid_a),
    .ex_ctrl(ex_ctrl_a), .ex_rd(ex_rd_a), .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a),
    .ex_illegal(ex_illegal_a), .illegal_seen(illegal_seen_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  id_ex_ctrl_pipe #(.CNT_W(2), .HAZARD_EN(1'b1), .CTRL_W(12)) dut_b (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_flush(ex_flush), .stall(stall_b), .ex_valid(ex_valid_b),
    .ex_ctrl(ex_ctrl_b), .ex_rd(ex_rd_b), .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b),
    .ex_illegal(ex_illegal_b), .illegal_seen(illegal_seen_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_valid;
  bit [11:0]  m_ctrl;
  bit [4:0]   m_rd, m_rs1, m_rs2;
  bit         m_ill, m_seen;
  int         m_stalls, m_flushes;   // raw event counts, saturated at compare
  bit         last_stall;            // model's stall for the latest step
  logic       obs_stall;             // DUT a stall seen in the latest step

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011,
    OPC_LD = 7'b0000011, OPC_ST = 7'b0100011, OPC_BR = 7'b1100011,
    OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111,
    OPC_AUIPC = 7'b0010111, OPC_BAD = 7'b1111111;

  // Decode table: control word and which source registers are read.
  task automatic ref_decode(input logic [31:0] ins, output bit [11:0] c,
                            output bit ill, output bit u1, output bit u2);
    c = 12'h000; ill = 1'b0; u1 = 1'b0; u2 = 1'b0;
    case (ins[6:0])
      OPC_R:     begin c = 12'h084; u1 = 1; u2 = 1; end
      OPC_I:     begin c = 12'h085; u1 = 1; end
      OPC_LD:    begin c = 12'h00F; u1 = 1; end
      OPC_ST:    begin c = 12'h011; u1 = 1; u2 = 1; end
      OPC_BR:    begin c = 12'h060; u1 = 1; u2 = 1; end
      OPC_JAL:   c = 12'hB04;
      OPC_JALR:  begin c = 12'h305; u1 = 1; end
      OPC_LUI:   c = 12'h405;
      OPC_AUIPC: c = 12'hC05;
      default:   ill = 1'b1;
    endcase
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd,
                                     input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'(rd), op};
  endfunction

  // One clock of stimulus: drive on the falling edge, check stall just after,
  // update the model at the rising edge and check registered outputs after it.
  task automatic step(input logic r, input logic [31:0] ins, input logic v,
                      input logic f, input string tag);
    bit [11:0] c;
    bit ill, u1, u2, es;
    @(negedge clk);
    rst = r; id_instr = ins; id_valid = v; ex_flush = f;
    #1;
    ref_decode(ins, c, ill, u1, u2);
    es = !r && v && m_valid && m_ctrl[3] && (m_rd != 0) && !f &&
         ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
    chk({tag, ".stall_a"}, 32'(stall_a), 32'(es));
    chk({tag, ".stall_b"}, 32'(stall_b), 32'(es));
    last_stall = es;
    obs_stall  = stall_a;
    $display("txn %0d %s rst=%0b instr=%08h v=%0b flush=%0b stall=%0b",
             txn, tag, r, ins, v, f, stall_a);
    txn++;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_ill = 0; m_seen = 0; m_stalls = 0; m_flushes = 0;
    end else if (f || es) begin
      m_valid = 0; m_ctrl = 0; m_ill = 0;
      if (f) m_flushes++;
      else   m_stalls++;
    end else begin
      m_valid = v;
      if (v) begin
        m_ctrl = c; m_ill = ill;
        m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
        if (ill) m_seen = 1;
      end else begin
        m_ctrl = 0; m_ill = 0;
      end
    end
    #1;
    chk({tag, ".valid"},   32'(ex_valid_a),     32'(m_valid));
    chk({tag, ".ctrl"},    32'(ex_ctrl_a),      32'(m_ctrl));
    chk({tag, ".illegal"}, 32'(ex_illegal_a),   32'(m_ill));
    chk({tag, ".seen"},    32'(illegal_seen_a), 32'(m_seen));
    chk({tag, ".ctrl_b"},  32'(ex_ctrl_b),      32'(m_ctrl));
    if (m_valid) begin
      chk({tag, ".rd"},  32'(ex_rd_a),  32'(m_rd));
      chk({tag, ".rs1"}, 32'(ex_rs1_a), 32'(m_rs1));
      chk({tag, ".rs2"}, 32'(ex_rs2_a), 32'(m_rs2));
    end
    chk({tag, ".scnt_a"}, 32'(stall_cnt_a), 32'(sat(m_stalls, 16)));
    chk({tag, ".fcnt_a"}, 32'(flush_cnt_a), 32'(sat(m_flushes, 16)));
    chk({tag, ".scnt_b"}, 32'(stall_cnt_b), 32'(sat(m_stalls, 2)));
    chk({tag, ".fcnt_b"}, 32'(flush_cnt_b), 32'(sat(m_flushes, 2)));
  endtask

  logic [6:0] op_pool [10];

  initial begin
    logic [31:0] ins;
    logic        v, f, r;

    op_pool = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR,
                OPC_LUI, OPC_AUIPC, OPC_BAD};

    // 1. reset, then add x3,x1,x2
    step(1, 0, 0, 0, "rst0");
    step(1, 0, 0, 0, "rst1");
    chk("t1.rst_valid", 32'(ex_valid_a), 32'h0);
    chk("t1.rst_ctrl",  32'(ex_ctrl_a),  32'h0);
    step(0, mk(OPC_R, 3, 1, 2), 1, 0, "add");
    chk("t1.add_ctrl", 32'(ex_ctrl_a), 32'h084);
    chk("t1.add_rd",   32'(ex_rd_a),   32'd3);

    // 2. lw x5 then dependent add: one-cycle stall, bubble, add next cycle
    step(0, mk(OPC_LD, 5, 1, 0), 1, 0, "lw5");
    step(0, mk(OPC_R, 6, 5, 2), 1, 0, "add_dep");
    chk("t2.stall",  32'(obs_stall),   32'd1);
    chk("t2.bubble", 32'(ex_valid_a),  32'd0);
    chk("t2.scnt",   32'(stall_cnt_a), 32'd1);
    step(0, mk(OPC_R, 6, 5, 2), 1, 0, "add_go");
    chk("t2.nostall", 32'(obs_stall), 32'd0);
    chk("t2.add_rd",  32'(ex_rd_a),   32'd6);

    // 3. x0 load never stalls; store data register (rs2) does
    step(0, mk(OPC_LD, 0, 1, 0), 1, 0, "lw0");
    step(0, mk(OPC_R, 6, 0, 2), 1, 0, "add_x0");
    chk("t3.x0_nostall", 32'(obs_stall), 32'd0);
    step(0, mk(OPC_LD, 5, 1, 0), 1, 0, "lw5b");
    step(0, mk(OPC_ST, 0, 1, 5), 1, 0, "sw_dep");
    chk("t3.sw_stall", 32'(obs_stall),   32'd1);
    chk("t3.scnt",     32'(stall_cnt_a), 32'd2);
    step(0, mk(OPC_ST, 0, 1, 5), 1, 0, "sw_go");

    // 4. flush wins over a load-use condition
    step(0, mk(OPC_LD, 5, 1, 0), 1, 0, "lw5c");
    step(0, mk(OPC_R, 6, 5, 2), 1, 1, "flush_dep");
    chk("t4.stall", 32'(obs_stall),   32'd0);
    chk("t4.fcnt",  32'(flush_cnt_a), 32'd1);
    chk("t4.scnt",  32'(stall_cnt_a), 32'd2);
    chk("t4.valid", 32'(ex_valid_a),  32'd0);

    // 5. illegal opcode, sticky flag
    step(0, mk(OPC_BAD, 1, 1, 1), 1, 0, "illegal");
    chk("t5.ill",  32'(ex_illegal_a),   32'd1);
    chk("t5.ctrl", 32'(ex_ctrl_a),      32'd0);
    chk("t5.seen", 32'(illegal_seen_a), 32'd1);
    step(0, mk(OPC_I, 2, 1, 0), 1, 0, "addi");
    step(0, 0, 0, 0, "idle");
    chk("t5.seen_hold", 32'(illegal_seen_a), 32'd1);

    // 6. saturation of the 2-bit counter, JAL and LUI decode
    for (int i = 0; i < 3; i++) begin
      step(0, mk(OPC_LD, 7, 1, 0), 1, 0, "sat_lw");
      step(0, mk(OPC_BR, 0, 7, 1), 1, 0, "sat_br");
      step(0, mk(OPC_BR, 0, 7, 1), 1, 0, "sat_br2");
    end
    chk("t6.sat_b", 32'(stall_cnt_b), 32'd3);
    chk("t6.cnt_a", 32'(stall_cnt_a), 32'd5);
    step(0, mk(OPC_JAL, 1, 0, 0), 1, 0, "jal");
    chk("t6.jal", 32'(ex_ctrl_a), 32'hB04);
    step(0, mk(OPC_LUI, 4, 0, 0), 1, 0, "lui");
    chk("t6.lui", 32'(ex_ctrl_a), 32'h405);
    step(1, 0, 0, 0, "rst2");
    chk("t5.seen_clr", 32'(illegal_seen_a), 32'd0);

    // Random traffic with small register numbers to provoke hazards.
    // A stalled instruction is re-presented, as the real IF/ID would hold it.
    ins = 0; v = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        ins = mk(op_pool[$urandom_range(0, 9)], $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        ins[31:25] = 7'($urandom);
        v = ($urandom_range(0, 9) < 8);
      end
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(r, ins, v, f, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
